// File: rtl/dac_pkg.sv
// Shared constants, frame-word builder and sequencer state encoding for the
// dual-channel galvo DAC SPI driver.
package dac_pkg;

  localparam int DAC_DATA_W = 12;
  localparam int FRAME_W    = 16;

  // Command nibble of an MCP4922-style write: {ch, BUF, GA_n, SHDN_n}
  localparam logic CH_A   = 1'b0;
  localparam logic CH_B   = 1'b1;
  localparam logic BUF    = 1'b0;
  localparam logic GA_N   = 1'b1;
  localparam logic SHDN_N = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_A = 3'd1,
    GAP     = 3'd2,
    FRAME_B = 3'd3,
    LATCH   = 3'd4
  } dac_state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic ch,
                                                    input logic [DAC_DATA_W-1:0] data);
    return {ch, BUF, GA_N, SHDN_N, data};
  endfunction

endpackage

// File: rtl/dac_spi_driver_spi_frame_tx.sv
// 16-bit SPI mode-0 serialiser: start loads a word, sclk toggles every CLK_DIV
// clocks, mosi advances on each falling edge, done pulses after the 16th fall.
module spi_frame_tx
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               sclk,
  output logic               mosi,
  output logic               done
);

  localparam int             DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FIRST = (CLK_DIV > 1) ? DIV_W'(1) : DIV_W'(0);
  // The start edge already counts as the first cycle of the first half-period
  localparam logic           SCLK_FIRST = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  logic               active_r;
  logic               sclk_r;
  logic               mosi_r;
  logic               done_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [3:0]         bit_cnt_r;
  logic [FRAME_W-2:0] shift_r;
  logic               toggle_s;

  assign toggle_s = active_r && (div_cnt_r == DIV_LAST);

  // Divider, sclk phase and bit shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r  <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      done_r    <= 1'b0;
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= 4'd0;
      shift_r   <= {(FRAME_W-1){1'b0}};
    end else if (start) begin
      active_r  <= 1'b1;
      sclk_r    <= SCLK_FIRST;
      mosi_r    <= word[FRAME_W-1];
      shift_r   <= word[FRAME_W-2:0];
      div_cnt_r <= DIV_FIRST;
      bit_cnt_r <= 4'd0;
      done_r    <= 1'b0;
    end else if (toggle_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      if (sclk_r) begin
        sclk_r <= 1'b0;
        if (bit_cnt_r == 4'd15) begin
          active_r  <= 1'b0;
          mosi_r    <= 1'b0;
          done_r    <= 1'b1;
          bit_cnt_r <= 4'd0;
        end else begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
          mosi_r    <= shift_r[FRAME_W-2];
          shift_r   <= {shift_r[FRAME_W-3:0], 1'b0};
          done_r    <= 1'b0;
        end
      end else begin
        sclk_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
      if (active_r) begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end else begin
        div_cnt_r <= {DIV_W{1'b0}};
      end
    end
  end

  assign sclk = sclk_r;
  assign mosi = mosi_r;
  assign done = done_r;

endmodule

// File: rtl/dac_spi_driver.sv
// Galvo DAC driver: frame A (x), chip-select gap, frame B (y), then one LDAC
// pulse. DAC_BLANK_ALIGN_EN delays the laser colour to the latch cycle.
module dac_spi_driver
  import dac_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 4,
  parameter int LATCH_LEN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DAC_DATA_W-1:0] sample_x,
  input  logic [DAC_DATA_W-1:0] sample_y,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [2:0]            laser_rgb_in,
  output logic [2:0]            laser_rgb,
  output logic                  dac_csn,
  output logic                  dac_sclk,
  output logic                  dac_mosi,
  output logic                  dac_latchn,
  output logic                  busy
);

  localparam int TMR_MAX = (CS_GAP > LATCH_LEN) ? CS_GAP : LATCH_LEN;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_LEN - 1);

  dac_state_e            state_r;
  dac_state_e            next_state_s;
  logic [TMR_W-1:0]      tmr_r;
  logic [TMR_W-1:0]      tmr_next_s;
  logic [DAC_DATA_W-1:0] y_r;
  logic                  accept_s;
  logic                  tx_start_s;
  logic [FRAME_W-1:0]    tx_word_s;
  logic                  tx_done_s;
  logic                  csn_r;
  logic                  latchn_r;
  logic                  ready_r;
  logic                  busy_r;
  logic [2:0]            rgb_r;

  assign accept_s = sample_valid && ready_r;

  spi_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst   (reset),
    .start (tx_start_s),
    .word  (tx_word_s),
    .sclk  (dac_sclk),
    .mosi  (dac_mosi),
    .done  (tx_done_s)
  );

  // Sequencer next-state, phase timer and frame launch
  always_comb begin
    next_state_s = state_r;
    tmr_next_s   = tmr_r;
    tx_start_s   = 1'b0;
    tx_word_s    = make_frame(CH_A, sample_x);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = FRAME_A;
          tx_start_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      FRAME_A: begin
        if (tx_done_s) begin
          next_state_s = GAP;
          tmr_next_s   = GAP_LOAD;
        end else begin
          next_state_s = FRAME_A;
        end
      end
      GAP: begin
        tx_word_s = make_frame(CH_B, y_r);
        if (tmr_r == {TMR_W{1'b0}}) begin
          next_state_s = FRAME_B;
          tx_start_s   = 1'b1;
        end else begin
          tmr_next_s = tmr_r - TMR_W'(1);
        end
      end
      FRAME_B: begin
        if (tx_done_s) begin
          next_state_s = LATCH;
          tmr_next_s   = LATCH_LOAD;
        end else begin
          next_state_s = FRAME_B;
        end
      end
      LATCH: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          next_state_s = IDLE;
        end else begin
          tmr_next_s = tmr_r - TMR_W'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        tmr_next_s   = {TMR_W{1'b0}};
      end
    endcase
  end

  // State register; pin drivers are registered from the next state so they
  // change on the same edge as the state itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      tmr_r    <= {TMR_W{1'b0}};
      y_r      <= {DAC_DATA_W{1'b0}};
      csn_r    <= 1'b1;
      latchn_r <= 1'b1;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      tmr_r    <= tmr_next_s;
      if (accept_s) begin
        y_r <= sample_y;
      end
      csn_r    <= !((next_state_s == FRAME_A) || (next_state_s == FRAME_B));
      latchn_r <= (next_state_s != LATCH);
      ready_r  <= (next_state_s == IDLE);
      busy_r   <= (next_state_s != IDLE);
    end
  end

`ifdef DAC_BLANK_ALIGN_EN
  logic [2:0] rgb_cap_r;

  // Colour captured at accept, released on entry to LATCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_cap_r <= 3'b000;
      rgb_r     <= 3'b000;
    end else begin
      if (accept_s) begin
        rgb_cap_r <= laser_rgb_in;
      end
      if ((next_state_s == LATCH) && (state_r != LATCH)) begin
        rgb_r <= rgb_cap_r;
      end
    end
  end
`else
  // Colour passes straight through one register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r <= 3'b000;
    end else begin
      rgb_r <= laser_rgb_in;
    end
  end
`endif

  assign sample_ready = ready_r;
  assign busy         = busy_r;
  assign dac_csn      = csn_r;
  assign dac_latchn   = latchn_r;
  assign laser_rgb    = rgb_r;

endmodule
